// File: rtl/branch_seq_uc.sv
// branch_seq_uc: multicycle branch sequencer driving the branch-condition evaluator and PC write.
// Optional BRANCH_STATS_EN adds saturating br_total/br_taken counters.
module branch_seq_uc #(
    parameter int CMP_WAIT = 0
`ifdef BRANCH_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic       update_UC,
    output logic       UC_control,
    output logic [1:0] UC_op,
    output logic       calc_target,
    output logic       compare,
    output logic       PC_write,
    output logic       busy,
    output logic       done,
    output logic       taken,
    output logic       invalid
`ifdef BRANCH_STATS_EN
    , output logic [CNT_W-1:0] br_total
    , output logic [CNT_W-1:0] br_taken
`endif
);
    typedef enum logic [1:0] {IDLE, TARGET, COMPARE, WRITE} state_t;
    state_t     state_q, state_d;
    logic [1:0] uc_op_q, uc_op_d;
    logic [3:0] cnt_q, cnt_d;
    logic       taken_q, taken_d;
    logic       invalid_q, invalid_d;
    logic       legal;
    assign legal = opcode[5:2] == 4'b0001;
    always_comb begin
        state_d   = state_q;
        uc_op_d   = uc_op_q;
        cnt_d     = cnt_q;
        taken_d   = taken_q;
        invalid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && legal) begin
                    state_d = TARGET;
                    uc_op_d = opcode[1:0];
                    taken_d = 1'b0;
                end
                invalid_d = start && !legal;
            end
            TARGET: begin
                state_d = COMPARE;
                cnt_d   = 4'(CMP_WAIT);
            end
            COMPARE: begin
                // the verdict is only trusted on the last settling cycle
                state_d = (cnt_q == 4'd0) ? WRITE : COMPARE;
                taken_d = (cnt_q == 4'd0) ? update_UC : taken_q;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            uc_op_q   <= 2'b00;
            cnt_q     <= 4'd0;
            taken_q   <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            uc_op_q   <= uc_op_d;
            cnt_q     <= cnt_d;
            taken_q   <= taken_d;
            invalid_q <= invalid_d;
        end
    end
    assign UC_control  = state_q == COMPARE;
    assign compare     = state_q == COMPARE;
    assign calc_target = state_q == TARGET;
    assign done        = state_q == WRITE;
    assign PC_write    = (state_q == WRITE) && taken_q;
    assign busy        = state_q != IDLE;
    assign UC_op       = uc_op_q;
    assign taken       = taken_q;
    assign invalid     = invalid_q;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] total_q, total_d, tkn_q, tkn_d;
    always_comb begin
        total_d = total_q;
        tkn_d   = tkn_q;
        if (state_q == WRITE) begin
            total_d = (&total_q) ? total_q : total_q + 1'b1;
            tkn_d   = (taken_q && !(&tkn_q)) ? tkn_q + 1'b1 : tkn_q;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            total_q <= '0;
            tkn_q   <= '0;
        end else begin
            total_q <= total_d;
            tkn_q   <= tkn_d;
        end
    end
    assign br_total = total_q;
    assign br_taken = tkn_q;
`endif
endmodule
